// File: rtl/spi_config_writer.sv
// spi_config_writer: SET/CLEAR register slots of a configuration-memory bank.
// Define SPI_CFG_VERIFY_EN to add read-back verification after each SET write.
module spi_config_writer #(
  parameter int MAX_NUM_REGISTERS = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_op,
  input  logic [1:0]  cmd_port,
  input  logic        cmd_dir,
  input  logic        cmd_nch,
  input  logic [6:0]  cmd_reg,
  input  logic [7:0]  cmd_data,
  output logic        done,
  output logic        err,
  output logic [1:0]  err_code,
  output logic        config_clk,
  output logic [10:0] config_addr,
  output logic        config_read,
  output logic        config_write,
  inout  wire  [7:0]  config_data
);
  localparam int SW = (MAX_NUM_REGISTERS > 1) ? $clog2(MAX_NUM_REGISTERS) : 1;
  localparam logic [SW-1:0] LAST = SW'(MAX_NUM_REGISTERS - 1);
  typedef enum logic [3:0] {
    IDLE, SCAN_ADDR, SCAN_WAIT, SCAN_CHECK, WRITE_DATA, WRITE_ADDR, CLEAR, VERIFY, DONE
  } state_t;
  state_t state;
  logic [SW-1:0] slot;
  logic [1:0] c_port;
  logic c_dir, c_nch;
  logic [6:0] c_reg;
  logic [7:0] c_data, wdata;
`ifdef SPI_CFG_VERIFY_EN
  logic [2:0] vphase;
  logic mism;
`endif
  // a = 1 selects the address entry of the slot, a = 0 its data entry
  function automatic logic [10:0] entry(input logic [1:0] p, input logic d, input logic n,
                                        input logic [SW-1:0] s, input logic a);
    return 11'h400 + {2'b00, p, d, n, 5'b00000} + 11'({s, a});
  endfunction
  assign config_clk = clk;
  assign config_data = config_write ? wdata : 8'bz;
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cmd_ready <= 1'b1;
      done <= 1'b0;
      err <= 1'b0;
      err_code <= 2'b00;
      config_addr <= '0;
      config_read <= 1'b0;
      config_write <= 1'b0;
      wdata <= '0;
      slot <= '0;
      c_port <= '0;
      c_dir <= 1'b0;
      c_nch <= 1'b0;
      c_reg <= '0;
      c_data <= '0;
`ifdef SPI_CFG_VERIFY_EN
      vphase <= '0;
      mism <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      err <= 1'b0;
      config_read <= 1'b0;
      case (state)
        IDLE: if (cmd_valid) begin
          cmd_ready <= 1'b0;
          err_code <= 2'b00;
          slot <= '0;
          c_port <= cmd_port;
          c_dir <= cmd_dir;
          c_nch <= cmd_nch;
          c_reg <= cmd_reg;
          c_data <= cmd_data;
          if (cmd_op[1]) begin
            state <= DONE;
            done <= 1'b1;
            err <= 1'b1;
            err_code <= 2'b11;
          end else if (cmd_op[0]) begin
            state <= CLEAR;
            config_addr <= entry(cmd_port, cmd_dir, cmd_nch, '0, 1'b1);
            config_write <= 1'b1;
            wdata <= 8'h00;
          end else begin
            state <= SCAN_ADDR;
            config_addr <= entry(cmd_port, cmd_dir, cmd_nch, '0, 1'b1);
            config_read <= 1'b1;
          end
        end
        SCAN_ADDR: state <= SCAN_WAIT;
        SCAN_WAIT: state <= SCAN_CHECK;
        // free or matching slot is written; otherwise move on or report full
        SCAN_CHECK: if (!config_data[7] || config_data[6:0] == c_reg) begin
          state <= WRITE_DATA;
          config_addr <= entry(c_port, c_dir, c_nch, slot, 1'b0);
          config_write <= 1'b1;
          wdata <= c_data;
        end else if (slot == LAST) begin
          state <= DONE;
          done <= 1'b1;
          err <= 1'b1;
          err_code <= 2'b01;
        end else begin
          state <= SCAN_ADDR;
          slot <= slot + 1'b1;
          config_addr <= entry(c_port, c_dir, c_nch, slot + 1'b1, 1'b1);
          config_read <= 1'b1;
        end
        WRITE_DATA: begin
          state <= WRITE_ADDR;
          config_addr <= entry(c_port, c_dir, c_nch, slot, 1'b1);
          wdata <= {1'b1, c_reg};
        end
        WRITE_ADDR: begin
          config_write <= 1'b0;
`ifdef SPI_CFG_VERIFY_EN
          state <= VERIFY;
          vphase <= '0;
          mism <= 1'b0;
          config_read <= 1'b1;
`else
          state <= DONE;
          done <= 1'b1;
`endif
        end
        CLEAR: if (slot == LAST) begin
          state <= DONE;
          config_write <= 1'b0;
          done <= 1'b1;
        end else begin
          slot <= slot + 1'b1;
          config_addr <= entry(c_port, c_dir, c_nch, slot + 1'b1, 1'b1);
        end
`ifdef SPI_CFG_VERIFY_EN
        // phases 0-2 read back the address entry, 3-5 the data entry
        VERIFY: if (vphase == 3'd2) begin
          vphase <= 3'd3;
          mism <= config_data != wdata;
          config_addr <= entry(c_port, c_dir, c_nch, slot, 1'b0);
          config_read <= 1'b1;
        end else if (vphase == 3'd5) begin
          state <= DONE;
          done <= 1'b1;
          err <= mism || config_data != c_data;
          err_code <= (mism || config_data != c_data) ? 2'b10 : 2'b00;
        end else begin
          vphase <= vphase + 3'd1;
        end
`endif
        DONE: begin
          state <= IDLE;
          cmd_ready <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
